// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment patterns and hex decode function.
// Patterns are active-low {a,b,c,d,e,f,g}, bit 6 = a; a 0 lights the segment.
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low segment pattern.
// Ports: nibble (4-bit hex digit in), pattern (7-bit active-low {a..g} out).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);
    assign pattern = hex_to_seg(nibble);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: N-digit multiplexed seven-segment driver with blank, blink, dp and dead time.
// Ports: clk, rst (sync active-high), en (display enable), digits_in (nibble per digit, MS nibble = digit 0),
// dp_in/blank_in/blink_in (per digit, bit N-1-i = digit i), segments/dp_out/anode_active (registered pins),
// frame_tick (pulse on the scan edge that wraps back to digit 0).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 100000,
    parameter int DEAD_CYCLES      = 16,
    parameter int BLINK_FRAMES     = 125,
    parameter int SEG_ACTIVE_LOW   = 1,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    output logic [6:0]              segments,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   anode_active,
    output logic                    frame_tick
);
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    // XOR masks that turn internal active-high/active-low patterns into pin levels
    localparam logic [6:0]            SEG_INV = SEG_ACTIVE_LOW != 0 ? 7'h00 : 7'h7f;
    localparam logic [6:0]            SEG_OFF = SEG_BLANK ^ SEG_INV;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW != 0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = ANODE_ACTIVE_LOW != 0 ? '1 : '0;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx, sel;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_phase, slot_end, frame_end, blink_wrap, lit;
    logic [3:0]            nibble;
    logic [6:0]            pattern;
    logic [NUM_DIGITS-1:0] onehot;

    // digit i lives at bit position NUM_DIGITS-1-i of every per-digit bus
    assign sel        = IW'(NUM_DIGITS - 1) - idx;
    assign nibble     = digits_in[{sel, 2'b00} +: 4];
    assign lit        = en && !blank_in[sel] && !(blink_in[sel] && blink_phase);
    assign slot_end   = cnt == CW'(REFRESH_DIV - 1);
    assign frame_end  = slot_end && idx == IW'(NUM_DIGITS - 1);
    assign blink_wrap = frame_cnt == FW'(BLINK_FRAMES - 1);
    assign onehot     = lit && cnt >= CW'(DEAD_CYCLES) ? NUM_DIGITS'(1) << sel : '0;

    seg7_hex_decode u_decode (.nibble(nibble), .pattern(pattern));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b0;
            frame_tick   <= 1'b0;
            segments     <= SEG_OFF;
            dp_out       <= DP_OFF;
            anode_active <= AN_OFF;
        end else begin
            cnt          <= en && !slot_end ? cnt + 1'b1 : '0;
            idx          <= !en || frame_end ? '0 : slot_end ? idx + 1'b1 : idx;
            frame_tick   <= en && frame_end;
            frame_cnt    <= en && frame_end ? (blink_wrap ? '0 : frame_cnt + 1'b1) : frame_cnt;
            blink_phase  <= blink_phase ^ (en && frame_end && blink_wrap);
            segments     <= lit ? pattern ^ SEG_INV : SEG_OFF;
            dp_out       <= (lit && dp_in[sel]) ^ DP_OFF;
            anode_active <= onehot ^ AN_OFF;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed and random checks of seg7_scan_driver against a slot-arithmetic model.
module tb_seg7_scan_driver;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int DC = 2;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0, blank_in = '0, blink_in = '0;
    logic [6:0]    segments;
    logic          dp_out, frame_tick;
    logic [3:0]    anode_active;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1), .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .segments(segments), .dp_out(dp_out),
        .anode_active(anode_active), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Independent active-low hex table, digit 0..F
    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Model: t = cycles since the display was (re)enabled, frames = completed frames since reset
    int t = 0;
    int frames = 0;
    int slot, pos;
    logic vis;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic exp_dp, exp_ft;

    always_comb begin
        slot = (t / RD) % ND;
        pos  = t % RD;
        vis  = !blank_in[ND-1-slot] && !(blink_in[ND-1-slot] && ((frames / BF) % 2 == 1));
    end

    always @(posedge clk) begin
        if (rst || !en) begin
            t       <= 0;
            exp_an  <= 4'hF;
            exp_seg <= 7'h7F;
            exp_dp  <= 1'b1;
            exp_ft  <= 1'b0;
            if (rst) frames <= 0;
        end else begin
            exp_an  <= vis && pos >= DC ? ~(4'b1000 >> slot) : 4'hF;
            exp_seg <= vis ? seg_tab[digits_in[(ND-1-slot)*4 +: 4]] : 7'h7F;
            exp_dp  <= !(vis && dp_in[ND-1-slot]);
            exp_ft  <= t % (RD * ND) == RD * ND - 1;
            t       <= t + 1;
            if (t % (RD * ND) == RD * ND - 1) frames <= frames + 1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("anode", 32'(anode_active), 32'(exp_an));
            chk("segments", 32'(segments), 32'(exp_seg));
            chk("dp", 32'(dp_out), 32'(exp_dp));
            chk("frame_tick", 32'(frame_tick), 32'(exp_ft));
            chk("one_anode", 32'($countones(~anode_active) <= 1), 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(3);
        chk("rst_anode", 32'(anode_active), 32'h0000000F);
        chk("rst_seg", 32'(segments), 32'h0000007F);
        chk("rst_dp", 32'(dp_out), 32'd1);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        checking  = 1'b1;
        rst       = 1'b0;
        en        = 1'b1;
        digits_in = 16'h12AF;
        step(2);
        chk("dead_t1", 32'(anode_active), 32'h0000000F);
        step(1);
        chk("slot0_an", 32'(anode_active), 32'h00000007);
        chk("slot0_seg", 32'(segments), 32'h0000004F);
        step(8);
        chk("slot1_an", 32'(anode_active), 32'h0000000B);
        chk("slot1_seg", 32'(segments), 32'h00000012);
        step(8);
        chk("slot2_an", 32'(anode_active), 32'h0000000D);
        chk("slot2_seg", 32'(segments), 32'h00000008);
        step(8);
        chk("slot3_an", 32'(anode_active), 32'h0000000E);
        chk("slot3_seg", 32'(segments), 32'h00000038);
        step(5);
        chk("tick_t31", 32'(frame_tick), 32'd1);
        step(1);
        chk("tick_t32", 32'(frame_tick), 32'd0);
        blank_in = 4'b0100;
        dp_in    = 4'b0001;
        step(10);
        chk("blank_slot1", 32'(anode_active), 32'h0000000F);
        step(16);
        chk("dp_slot3_an", 32'(anode_active), 32'h0000000E);
        chk("dp_slot3", 32'(dp_out), 32'd0);
        blank_in = 4'b0000;
        dp_in    = 4'b0000;
        blink_in = 4'b1000;
        step(8);
        chk("blink_dark", 32'(anode_active), 32'h0000000F);
        step(64);
        chk("blink_lit_an", 32'(anode_active), 32'h00000007);
        chk("blink_lit_seg", 32'(segments), 32'h0000004F);
        step(17);
        en = 1'b0;
        step(1);
        chk("en_off_an", 32'(anode_active), 32'h0000000F);
        chk("en_off_seg", 32'(segments), 32'h0000007F);
        step(3);
        en = 1'b1;
        step(1);
        chk("reen_dead", 32'(anode_active), 32'h0000000F);
        step(2);
        chk("reen_digit0", 32'(anode_active), 32'h00000007);
        step(10);
        rst = 1'b1;
        step(1);
        chk("midrst_an", 32'(anode_active), 32'h0000000F);
        rst = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            digits_in = 16'($urandom);
            dp_in     = 4'($urandom);
            blank_in  = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0000;
            blink_in  = 4'($urandom);
            en        = $urandom_range(0, 99) != 0;
            rst       = $urandom_range(0, 999) == 0;
            step(1);
        end
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
